inst_fetch_responder: RTL and testbench

//  Instruction-side bus responder for the IF stage.
//  - Accepts 16-byte-aligned fetch requests from the fetch stage and queues them in order.
//  - Fetches each 4-word line from memory with a BEATS-word read burst.
//  - Returns the 128-bit line with a one-cycle inst_data_ok pulse, in request order.
//  - Cancellation is the consumer's job: every accepted request gets exactly one inst_data_ok.

---
 rtl/inst_fetch_responder.sv | 206 ++++++++++++++++++++
 tb/tb_inst_fetch_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
// Instruction-side bus responder for the IF stage.
// Queues line-aligned fetch requests in order, fetches each line with a read burst and
// returns it with a one-cycle inst_data_ok pulse. Define ICACHE_LINEBUF_EN to add a
// one-entry line buffer that answers repeated fetches of the same line without memory.
module inst_fetch_responder #(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned BEATS  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inst_req,
    input  logic [31:0]  inst_addr,
    output logic         inst_addr_ok,
    output logic         inst_data_ok,
    output logic [127:0] inst_rdata,
    input  logic         inv_i,
    output logic         mem_rd_req,
    output logic [31:0]  mem_rd_addr,
    input  logic         mem_rd_ready,
    input  logic         mem_rd_valid,
    input  logic [31:0]  mem_rd_data,
    input  logic         mem_rd_last
);

    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
    localparam int unsigned BEAT_W = $clog2(BEATS);

    localparam logic [PTR_W-1:0]  PtrLast  = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0]  CntFull  = CNT_W'(QDEPTH);
    localparam logic [BEAT_W-1:0] BeatLast = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [27:0]         q_mem [QDEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [31:0]         word_q [BEATS];
    logic [127:0]        inst_rdata_q;
    logic [127:0]        line_asm;
    logic [127:0]        buf_line;
    logic [27:0]         head;
    logic                push, pop;
    logic                load_mem, load_buf;
    logic                head_hit, in_hit;
    logic                unused_sig;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PtrLast) ? '0 : p + PTR_W'(1);
    endfunction

    // No pass-through when full: a slot must already be free.
    assign inst_addr_ok = rst && (count_q < CntFull);
    assign push         = inst_req && inst_addr_ok;
    assign pop          = (state_q == StResp);
    assign head         = q_mem[rd_ptr_q];
    assign inst_rdata   = inst_rdata_q;

    // Queue storage: tag of each accepted request
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_q] <= inst_addr[31:4];
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Next state, burst request outputs and response pulse
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        load_mem     = 1'b0;
        load_buf     = 1'b0;
        mem_rd_req   = 1'b0;
        mem_rd_addr  = '0;
        inst_data_ok = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    if (head_hit) begin
                        state_d  = StResp;
                        load_buf = 1'b1;
                    end else begin
                        state_d = StAddr;
                    end
                end else if (push && !in_hit) begin
                    // A miss entering an empty queue starts its burst right away;
                    // a hit waits one cycle and is answered from the head compare.
                    state_d = StAddr;
                end
            end
            StAddr: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = {head, 4'b0};
                if (mem_rd_ready) begin
                    state_d = StData;
                    beat_d  = '0;
                end
            end
            StData: begin
                if (mem_rd_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BeatLast) begin
                        state_d  = StResp;
                        load_mem = 1'b1;
                    end
                end
            end
            StResp: begin
                inst_data_ok = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Line image on the final beat: stored words below, live beat on top
    always_comb begin
        line_asm = '0;
        for (int i = 0; i < int'(BEATS) - 1; i++) begin
            line_asm[i*32 +: 32] = word_q[i];
        end
        line_asm[(BEATS-1)*32 +: 32] = mem_rd_data;
    end

    // State, beat counter and registered response line
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            inst_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (load_mem) begin
                inst_rdata_q <= line_asm;
            end else if (load_buf) begin
                inst_rdata_q <= buf_line;
            end
        end
    end

    // Beat capture; valid outside DATA is ignored
    always_ff @(posedge clk) begin
        if (state_q == StData && mem_rd_valid) begin
            word_q[beat_q] <= mem_rd_data;
        end
    end

`ifdef ICACHE_LINEBUF_EN
    logic         buf_valid_q;
    logic [27:0]  buf_tag_q;
    logic [127:0] buf_line_q;

    assign head_hit   = buf_valid_q && (head == buf_tag_q);
    assign in_hit     = buf_valid_q && (inst_addr[31:4] == buf_tag_q);
    assign buf_line   = buf_line_q;
    assign unused_sig = ^{mem_rd_last, inst_addr[3:0]};

    // Buffer valid: set by every response, invalidate has priority
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
        end else if (inv_i) begin
            buf_valid_q <= 1'b0;
        end else if (state_q == StResp) begin
            buf_valid_q <= 1'b1;
        end
    end

    // Buffer contents: the line being returned
    always_ff @(posedge clk) begin
        if (state_q == StResp) begin
            buf_tag_q  <= head;
            buf_line_q <= inst_rdata_q;
        end
    end
`else
    assign head_hit   = 1'b0;
    assign in_hit     = 1'b0;
    assign buf_line   = '0;
    assign unused_sig = ^{mem_rd_last, inst_addr[3:0], inv_i};
`endif

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: table of single-request vectors plus
// hand-written sequences for queue-full, accept-during-response, reset mid-burst and,
// with ICACHE_LINEBUF_EN, line buffer hits and invalidation.
module tb_inst_fetch_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inst_req = 1'b0;
    logic [31:0]  inst_addr = '0;
    logic         inst_addr_ok;
    logic         inst_data_ok;
    logic [127:0] inst_rdata;
    logic         inv_i = 1'b0;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_ready = 1'b0;
    logic         mem_rd_valid = 1'b0;
    logic [31:0]  mem_rd_data = '0;
    logic         mem_rd_last = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_responder #(.QDEPTH(2), .BEATS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inv_i        (inv_i),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_ready (mem_rd_ready),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_last  (mem_rd_last)
    );

    int n_applied = 0;
    int n_miss    = 0;
    int cyc       = 0;

    logic [127:0] got_q[$];
    int           got_cyc[$];
    logic [31:0]  burst_addr[$];
    int           bursts   = 0;
    int           unstable = 0;
    logic         prev_req = 1'b0;
    logic [31:0]  prev_addr = '0;

    int ready_wait = 0;
    int gap_len    = 0;

    // Memory contents: special line for the boot vector, byte address elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
        if (line == 32'hBFC0_0000) return 32'h11 * (i + 1);
        return line + 32'(4 * i);
    endfunction

    // Memory model: optional ready wait (with junk valids), optional gap after beat 1
    initial begin
        int m_left, m_idx, m_wait, m_gap;
        logic [31:0] m_addr;
        logic rst_seen;
        m_left = 0; m_idx = 0; m_wait = 0; m_gap = 0; m_addr = '0;
        forever begin
            @(posedge clk);
            rst_seen = rst;
            #2;
            mem_rd_ready = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rd_last  = 1'b0;
            mem_rd_data  = '0;
            if (!rst_seen) begin
                m_left = 0; m_wait = 0; m_gap = 0;
            end else if (m_left > 0) begin
                if (m_gap > 0) begin
                    m_gap--;
                end else begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem_word(m_addr, m_idx);
                    mem_rd_last  = (m_left == 1);
                    m_idx++;
                    m_left--;
                    if (m_idx == 2) m_gap = gap_len;
                end
            end else if (mem_rd_req) begin
                if (m_wait < ready_wait) begin
                    m_wait++;
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = 32'hDEAD_BEEF;
                end else begin
                    mem_rd_ready = 1'b1;
                    m_addr = mem_rd_addr;
                    m_left = 4; m_idx = 0; m_wait = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < got_cyc.size()) return got_cyc[i];
        return -1000;
    endfunction

    function automatic logic [31:0] baddr_at(input int i);
        if (i < burst_addr.size()) return burst_addr[i];
        return 'x;
    endfunction

    task automatic clear_log();
        got_q.delete(); got_cyc.delete(); burst_addr.delete();
        bursts = 0; unstable = 0;
    endtask

    // Advance one cycle and sample DUT outputs 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (inst_data_ok) begin
            got_q.push_back(inst_rdata);
            got_cyc.push_back(cyc);
        end
        if (mem_rd_req && !prev_req) begin
            bursts++;
            burst_addr.push_back(mem_rd_addr);
        end
        if (mem_rd_req && prev_req && mem_rd_addr != prev_addr) unstable++;
        prev_req  = mem_rd_req;
        prev_addr = mem_rd_addr;
    endtask

    // Present one request until accepted; returns the accept cycle, ends one cycle later
    task automatic req_one(input logic [31:0] a, output int acc);
        int n;
        n = 0;
        inst_req  = 1'b1;
        inst_addr = a;
        while (!inst_addr_ok && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("accept_%h", a), inst_addr_ok, 1'b1);
        acc = cyc;
        tick();
        inst_req = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 100) begin
            tick();
            k++;
        end
        check($sformatf("resp_count_reached_%0d", n), got_q.size() >= n, 1'b1);
    endtask

    typedef struct {
        logic [31:0]  addr;
        int           wait_c;
        int           gap;
        logic [31:0]  exp_maddr;
        logic [127:0] exp_data;
        int           exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int acc, acc2, acc3, c_ok, n;

        vecs[0] = '{32'hBFC0_0004, 0, 0, 32'hBFC0_0000,
                    128'h00000044_00000033_00000022_00000011, 6};
        vecs[1] = '{32'h0000_1000, 0, 0, 32'h0000_1000,
                    128'h0000100C_00001008_00001004_00001000, 6};
        vecs[2] = '{32'h8000_ABCF, 2, 0, 32'h8000_ABC0,
                    128'h8000ABCC_8000ABC8_8000ABC4_8000ABC0, 8};
        vecs[3] = '{32'h2000_0010, 5, 2, 32'h2000_0010,
                    128'h2000001C_20000018_20000014_20000010, 13};

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check("rst_data_ok", inst_data_ok, 1'b0);
        check("rst_rdata", inst_rdata, 128'h0);
        check("rst_mem_req", mem_rd_req, 1'b0);
        check("rst_mem_addr", mem_rd_addr, 32'h0);
        check("rst_addr_ok_low", inst_addr_ok, 1'b0);
        rst = 1'b1;
        tick();
        check("post_rst_addr_ok", inst_addr_ok, 1'b1);

        // Single-request vectors
        for (int i = 0; i < 4; i++) begin
            ready_wait = vecs[i].wait_c;
            gap_len    = vecs[i].gap;
            clear_log();
            req_one(vecs[i].addr, acc);
            wait_resp(1);
            repeat (3) tick();
            check($sformatf("vec%0d_maddr", i), baddr_at(0), vecs[i].exp_maddr);
            check($sformatf("vec%0d_data", i), got_at(0), vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), cyc_at(0) - acc, vecs[i].exp_lat);
            check($sformatf("vec%0d_one_resp", i), got_q.size(), 1);
            check($sformatf("vec%0d_one_burst", i), bursts, 1);
            check($sformatf("vec%0d_req_stable", i), unstable, 0);
        end
        ready_wait = 0;
        gap_len    = 0;

        // Three back-to-back requests against a two-deep queue
        clear_log();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_3000;
        check("q3_ok_first", inst_addr_ok, 1'b1);
        acc = cyc;
        tick();
        inst_addr = 32'h0000_4004;
        check("q3_ok_second", inst_addr_ok, 1'b1);
        tick();
        inst_addr = 32'h0000_5008;
        check("q3_full", inst_addr_ok, 1'b0);
        n = 0;
        while (!inst_addr_ok && n < 60) begin
            tick();
            n++;
        end
        c_ok = cyc;
        tick();
        inst_req = 1'b0;
        check("q3_first_latency", cyc_at(0) - acc, 6);
        check("q3_ok_after_first_resp", c_ok, cyc_at(0) + 1);
        wait_resp(3);
        repeat (2) tick();
        check("q3_resp_count", got_q.size(), 3);
        check("q3_data0", got_at(0), 128'h0000300C_00003008_00003004_00003000);
        check("q3_data1", got_at(1), 128'h0000400C_00004008_00004004_00004000);
        check("q3_data2", got_at(2), 128'h0000500C_00005008_00005004_00005000);
        check("q3_burst2_addr", baddr_at(2), 32'h0000_5000);

        // Request accepted during a response with one entry queued
        clear_log();
        req_one(32'h0000_9000, acc);
        repeat (5) tick();
        check("r6_in_resp", inst_data_ok, 1'b1);
        inst_req  = 1'b1;
        inst_addr = 32'h0000_A000;
        check("r6_accept_in_resp", inst_addr_ok, 1'b1);
        tick();
        inst_addr = 32'h0000_B000;
        check("r6_count_stays_one", inst_addr_ok, 1'b1);
        tick();
        check("r6_full_after_two", inst_addr_ok, 1'b0);
        inst_req = 1'b0;
        wait_resp(3);
        repeat (2) tick();
        check("r6_next_burst_addr", baddr_at(1), 32'h0000_A000);
        check("r6_data_y", got_at(1), 128'h0000A00C_0000A008_0000A004_0000A000);
        check("r6_data_z", got_at(2), 128'h0000B00C_0000B008_0000B004_0000B000);
        check("r6_latency_y", cyc_at(1) - acc, 13);

        // Reset during the DATA beat 2 cycle
        clear_log();
        req_one(32'h0000_6000, acc);
        check("rb_req_up", mem_rd_req, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rb_data_ok", inst_data_ok, 1'b0);
        check("rb_rdata", inst_rdata, 128'h0);
        check("rb_mem_req", mem_rd_req, 1'b0);
        check("rb_mem_addr", mem_rd_addr, 32'h0);
        check("rb_addr_ok_low", inst_addr_ok, 1'b0);
        rst = 1'b1;
        repeat (6) tick();
        check("rb_no_new_burst", bursts, 1);
        check("rb_no_resp", got_q.size(), 0);
        check("rb_addr_ok", inst_addr_ok, 1'b1);
        clear_log();
        req_one(32'h0000_7000, acc);
        wait_resp(1);
        repeat (2) tick();
        check("rb_after_data", got_at(0), 128'h0000700C_00007008_00007004_00007000);
        check("rb_after_latency", cyc_at(0) - acc, 6);

`ifdef ICACHE_LINEBUF_EN
        // Line buffer hit, then invalidate
        clear_log();
        req_one(32'h0000_1000, acc);
        wait_resp(1);
        repeat (2) tick();
        req_one(32'h0000_1008, acc2);
        wait_resp(2);
        repeat (2) tick();
        check("lb_hit_no_burst", bursts, 1);
        check("lb_hit_data", got_at(1), 128'h0000100C_00001008_00001004_00001000);
        check("lb_hit_latency", cyc_at(1) - acc2, 2);
        inv_i = 1'b1;
        tick();
        inv_i = 1'b0;
        req_one(32'h0000_1000, acc3);
        wait_resp(3);
        repeat (2) tick();
        check("lb_inv_burst", bursts, 2);
        check("lb_inv_latency", cyc_at(2) - acc3, 6);
        check("lb_inv_data", got_at(2), 128'h0000100C_00001008_00001004_00001000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
